manchester_rx: RTL

MANCHESTER_RX -- requirements
Module: manchester_rx

---
 rtl/manchester_pkg.sv | 12 +
 rtl/manchester_pair_decoder.sv | 20 ++
 rtl/manchester_rx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/manchester_pkg.sv
// rtl/manchester_pkg.sv - shared Manchester line constants and receiver state encoding
package manchester_pkg;
    localparam logic [15:0] SYNC_WORD_DEF = 16'hAAD5;
    localparam logic [1:0]  MAN_ONE_DEF   = 2'b10;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'hAA;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } rx_state_e;
endpackage

// File: rtl/manchester_pair_decoder.sv
// rtl/manchester_pair_decoder.sv - decodes four half-bit pairs of an 8-sample window, oldest pair first
module manchester_pair_decoder
    import manchester_pkg::*;
#(
    parameter logic [1:0] MAN_ONE = MAN_ONE_DEF
) (
    input  logic [7:0] win,
    output logic [3:0] bits,
    output logic [3:0] viol
);
    always_comb begin
        bits = '0;
        viol = '0;
        // bits[3]/viol[3] come from win[7:6], the oldest pair
        for (int i = 0; i < 4; i++) begin
            bits[3-i] = (win[7-2*i -: 2] == MAN_ONE);
            viol[3-i] = (win[7-2*i -: 2] == 2'b00) || (win[7-2*i -: 2] == 2'b11);
        end
    end
endmodule

// File: rtl/manchester_rx.sv
// rtl/manchester_rx.sv - Manchester receiver: phase hunt, sync-word lock and byte framing
module manchester_rx
    import manchester_pkg::*;
#(
    parameter int          FRAME_LEN = 6,
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter logic [1:0]  MAN_ONE   = MAN_ONE_DEF
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [7:0] din,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    output logic       locked,
    output logic       frame_err
);
    rx_state_e   state_q, state_d;
    logic        phase_q, phase_d;
    logic        prev_din0_q;
    logic [14:0] hist_q, hist_d;
    logic [6:0]  asm_q, asm_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d;
    logic        m_last_q, m_last_d;
    logic        frame_err_q, frame_err_d;

    logic [7:0]  win;
    logic [3:0]  bits;
    logic [3:0]  viol;
    logic        any_viol;
    logic [18:0] hist_cat;
    logic [10:0] asm_cat;
    logic        found;

    // Phase 1 shifts the pairing by one sample, borrowing the last sample of the previous word
    assign win      = phase_q ? {prev_din0_q, din[7:1]} : din;
    assign any_viol = |viol;
    // 19-bit history: 15 retained bits followed by this cycle's 4 new bits
    assign hist_cat = {hist_q, bits};
    // Assembler holds bit_cnt_q valid bits in its low end; new bits append below them
    assign asm_cat  = {asm_q, bits};

    manchester_pair_decoder #(.MAN_ONE(MAN_ONE)) u_pair_dec (
        .win  (win),
        .bits (bits),
        .viol (viol)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        hist_d      = hist_q;
        asm_d       = asm_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        m_data_d    = m_data_q;
        m_valid_d   = 1'b0;
        m_last_d    = 1'b0;
        frame_err_d = 1'b0;
        found       = 1'b0;
        case (state_q)
            HUNT: begin
                if (any_viol) begin
                    phase_d = ~phase_q;
                    hist_d  = '0;
                end else begin
                    hist_d = hist_cat[14:0];
                    for (int k = 0; k < 4; k++) begin
                        if (!found && hist_cat[18-k -: 16] == SYNC_WORD) begin
                            found      = 1'b1;
                            state_d    = RECV;
                            hist_d     = '0;
                            asm_d      = {3'b000, bits};
                            bit_cnt_d  = 3'(3 - k);
                            byte_cnt_d = '0;
                        end
                    end
                end
            end
            RECV: begin
                if (any_viol) begin
                    state_d     = HUNT;
                    phase_d     = ~phase_q;
                    frame_err_d = 1'b1;
                    hist_d      = '0;
                    asm_d       = '0;
                    bit_cnt_d   = '0;
                    byte_cnt_d  = '0;
                end else if (bit_cnt_q[2]) begin
                    // 8 or more bits now available; the oldest 8 form the byte, the rest carry
                    m_valid_d = 1'b1;
                    m_data_d  = asm_cat[bit_cnt_q[1:0] +: 8];
                    asm_d     = asm_cat[6:0];
                    bit_cnt_d = {1'b0, bit_cnt_q[1:0]};
                    if (byte_cnt_q == 8'(FRAME_LEN - 1)) begin
                        m_last_d   = 1'b1;
                        state_d    = HUNT;
                        hist_d     = '0;
                        asm_d      = '0;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end else begin
                    asm_d     = asm_cat[6:0];
                    bit_cnt_d = {1'b1, bit_cnt_q[1:0]};
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= HUNT;
            phase_q     <= 1'b0;
            prev_din0_q <= 1'b0;
            hist_q      <= '0;
            asm_q       <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            prev_din0_q <= din[0];
            hist_q      <= hist_d;
            asm_q       <= asm_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign locked    = (state_q == RECV);
    assign frame_err = frame_err_q;
endmodule
